score_keeper: RTL
=================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter POINTS, default 1, score increment per eat pulse; legal range 1..99.
REQ-002 Parameter MAX_SCORE, default 999, saturation ceiling; legal range 1..999.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 eat  input  1  one-cycle pulse, snake consumed food; add POINTS.
REQ-006 new_game  input  1  one-cycle pulse; clear current score and keep high score.
REQ-007 show_high  input  1  level; 1 selects high_score for display, 0 selects score.
REQ-008 score  output  16  current score, binary.
REQ-009 high_score  output  16  maximum score since reset, binary.
REQ-010 digit2, digit1, digit0  output  4 each  BCD hundreds/tens/ones of the displayed value; they drive the existing 7-seg decoders.
REQ-011 busy  output  1  high while a BCD conversion is in progress.

Function
REQ-012 On an edge with new_game=1, score SHALL become 0, and eat in the same cycle SHALL be ignored.
REQ-013 On an edge with eat=1 and new_game=0, score SHALL become min(score+POINTS, MAX_SCORE); the sum SHALL be computed 17 bits wide, with no wrap.
REQ-014 On the same edge as any score update, high_score SHALL become max(high_score, new score).
REQ-015 A dirty flag SHALL be set on any edge where the selected display value changes: a score/high_score change that affects the selection, or a toggle of show_high.
REQ-016 If eat occurs with score already at MAX_SCORE, the value is unchanged and dirty SHALL NOT be set.
REQ-017 The converter FSM SHALL have states IDLE, CONV, DONE.
REQ-018 IDLE -> CONV SHALL occur on the first edge with dirty=1. On that edge:
 - load the 10-bit selected value into the shift register
 - clear the 12-bit BCD accumulator
 - clear the bit counter
 - clear dirty, unless a new change is flagged on that same edge
REQ-019 Each CONV cycle SHALL add 3 to every BCD nibble that is >=5, then shift {BCD,bin} left by 1 and increment the counter.
REQ-020 CONV SHALL take exactly 10 cycles and then go to DONE.
REQ-021 On entry to DONE, digit2..digit0 SHALL load the accumulator; DONE -> IDLE SHALL occur on the next edge.
REQ-022 Digit outputs SHALL stay stable at the previous result during CONV; no intermediate values are visible.
REQ-023 busy SHALL be 1 in CONV and DONE and 0 in IDLE.
REQ-024 Latency: digits SHALL reflect a change 12 edges after the edge that registered it, when the FSM is IDLE at that time.
REQ-025 A change arriving during CONV/DONE SHALL set dirty and SHALL NOT abort the current conversion. A new conversion of the then-current value SHALL start on the first IDLE edge, so the final digits always match the final value.
REQ-026 Toggling show_high while busy SHALL follow the same rule as REQ-025.

Reset
REQ-027 While reset_n=0, the following SHALL be forced asynchronously and held:
 - score=0, high_score=0
 - digit2=digit1=digit0=0
 - busy=0, dirty=0
 - state=IDLE, shift register and counter cleared
REQ-028 Asserting reset_n mid-conversion SHALL abandon the conversion. After release, no conversion SHALL start until a new change is flagged.
REQ-029 Operation SHALL resume on the first rising edge after reset_n returns high.

Verification
REQ-030 Reset, show_high=0, 5 eat pulses spaced 20 cycles -> score=5, high_score=5, digits 0/0/5 exactly 12 edges after the last eat, busy high for 11 cycles.
REQ-031 Drive score to 998, then 3 back-to-back eats -> score=999 saturated, high_score=999, digits 9/9/9; the third eat causes no extra conversion.
REQ-032 Eat at score 41 while busy converting 41 -> digits go 4/1 and then 4/2 with no intermediate values; the second busy window starts on the edge after DONE.
REQ-033 Score 57, then new_game+eat in the same cycle -> score=0, high_score=57. Setting show_high=1 -> digits 0/5/7; show_high=0 -> digits 0/0/0.
REQ-034 Drop reset_n for 3 cycles at CONV cycle 4 -> all outputs 0 immediately; busy stays 0 after release until the next eat.
REQ-035 Sweep score 0..999 via single eats and compare digits against decimal after each conversion; all 1000 values match.

Source files
------------

// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - game-side controls and score/display outputs of score_keeper
interface score_keeper_if;
    logic        eat;
    logic        new_game;
    logic        show_high;
    logic [15:0] score;
    logic [15:0] high_score;
    logic [3:0]  digit2;
    logic [3:0]  digit1;
    logic [3:0]  digit0;
    logic        busy;

    modport master (
        output eat, new_game, show_high,
        input  score, high_score, digit2, digit1, digit0, busy
    );

    modport slave (
        input  eat, new_game, show_high,
        output score, high_score, digit2, digit1, digit0, busy
    );
endinterface

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - saturating score/high-score counter with a serial binary-to-BCD display converter
module score_keeper #(
    parameter int POINTS    = 1,
    parameter int MAX_SCORE = 999
) (
    input  logic          clk,
    input  logic          reset_n,
    score_keeper_if.slave sk
);
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_CONV = 2'd1;
    localparam logic [1:0]  S_DONE = 2'd2;
    localparam logic [16:0] MAX17  = 17'(MAX_SCORE);
    localparam logic [16:0] PTS17  = 17'(POINTS);

    logic [15:0] r_score;
    logic [15:0] r_high;
    logic        r_show_q;
    logic        r_dirty;
    logic [1:0]  r_state;
    logic [9:0]  r_bin;
    logic [11:0] r_bcd;
    logic [3:0]  r_cnt;
    logic [3:0]  r_d2;
    logic [3:0]  r_d1;
    logic [3:0]  r_d0;

    logic [16:0] w_sum;
    logic [15:0] w_score_nxt;
    logic [15:0] w_high_nxt;
    logic [15:0] w_disp_cur;
    logic [15:0] w_disp_nxt;
    logic        w_change;
    logic        w_start;
    logic [11:0] w_bcd_adj;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        w_sum       = {1'b0, r_score} + PTS17;
        w_score_nxt = r_score;
        if (sk.new_game) begin
            w_score_nxt = 16'd0;
        end else if (sk.eat) begin
            w_score_nxt = (w_sum >= MAX17) ? MAX17[15:0] : w_sum[15:0];
        end
        w_high_nxt = (w_score_nxt > r_high) ? w_score_nxt : r_high;
        // A show_high toggle counts as a change even when both values are equal.
        w_disp_cur = r_show_q ? r_high : r_score;
        w_disp_nxt = sk.show_high ? w_high_nxt : w_score_nxt;
        w_change   = (sk.show_high != r_show_q) || (w_disp_nxt != w_disp_cur);
        w_start    = (r_state == S_IDLE) && r_dirty;
        w_bcd_adj  = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_score  <= 16'd0;
            r_high   <= 16'd0;
            r_show_q <= 1'b0;
            r_dirty  <= 1'b0;
        end else begin
            r_score  <= w_score_nxt;
            r_high   <= w_high_nxt;
            r_show_q <= sk.show_high;
            r_dirty  <= w_change | (r_dirty & ~w_start);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_bin   <= 10'd0;
            r_bcd   <= 12'd0;
            r_cnt   <= 4'd0;
            r_d2    <= 4'd0;
            r_d1    <= 4'd0;
            r_d0    <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_dirty) begin
                        r_state <= S_CONV;
                        r_bin   <= w_disp_cur[9:0];
                        r_bcd   <= 12'd0;
                        r_cnt   <= 4'd0;
                    end
                end
                S_CONV: begin
                    r_bcd <= {w_bcd_adj[10:0], r_bin[9]};
                    r_bin <= {r_bin[8:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_d2    <= r_bcd[11:8];
                    r_d1    <= r_bcd[7:4];
                    r_d0    <= r_bcd[3:0];
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sk.score      = r_score;
    assign sk.high_score = r_high;
    assign sk.digit2     = r_d2;
    assign sk.digit1     = r_d1;
    assign sk.digit0     = r_d0;
    assign sk.busy       = (r_state != S_IDLE);
endmodule
